// File: rtl/speck_core_arbiter_pkg.sv
// Shared definitions for the SPECK core arbiter family.
// Holds the arbiter FSM encodings, the default quiet/watchdog periods and
// the round-robin pointer helper shared with the grant picker.
// KEY_SIZE normally comes from cipher_settings; a 128-bit fallback keeps
// this slice self-contained when that header is not part of the build.

`ifndef KEY_SIZE
`define KEY_SIZE 128
`endif

package speck_core_arbiter_pkg;

  // Arbiter FSM encodings (kept as plain constants for legacy tooling)
  localparam logic [2:0] ARB_FLUSH  = 3'd0;
  localparam logic [2:0] ARB_IDLE   = 3'd1;
  localparam logic [2:0] ARB_LAUNCH = 3'd2;
  localparam logic [2:0] ARB_BUSY   = 3'd3;
  localparam logic [2:0] ARB_RESP   = 3'd4;

  // Operand width shared with the encrypt core
  localparam int ARB_DATA_W = `KEY_SIZE;

  // Default quiet period after reset; must cover the core's worst-case latency
  localparam int ARB_FLUSH_CYCLES = 1024;

  // Default watchdog limit for the optional timeout logic
  localparam int ARB_TIMEOUT_CYCLES = 2048;

  // Next round-robin starting point after index idx has been served
  function automatic int rr_next(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/speck_core_arbiter_rr_grant.sv
// Combinational round-robin priority picker.
// Searches the request vector upward starting at ptr, wrapping around, and
// reports the first set requester as a one-hot grant plus its index.
// Kept generic so the decrypt-side arbitration can reuse it unchanged.

module rr_grant
  import speck_core_arbiter_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] idx,
  output logic                 any_valid
);

  localparam int IDX_W = $clog2(N);

  int pos;

  // Walk the requesters from ptr upward with wrap, first hit wins
  always_comb begin
    grant     = '0;
    idx       = '0;
    any_valid = 1'b0;
    pos       = 0;
    for (int k = 0; k < N; k++) begin
      pos = (int'(ptr) + k) % N;
      if (!any_valid && req[pos]) begin
        any_valid  = 1'b1;
        grant[pos] = 1'b1;
        idx        = IDX_W'(pos);
      end
    end
  end

endmodule

// File: rtl/speck_core_arbiter.sv
// Round-robin arbiter sharing one SPECK encrypt core between NUM_REQ
// requesters. A winner's operands are latched, the core is started with a
// one-cycle pulse, and the ciphertext comes back on a valid/ready response
// channel tagged with the requester id.
// After reset the FSM sits in FLUSH long enough for any job the core was
// running (it has no reset) to finish, so a stale finished pulse is absorbed.
// Optional macro SPECK_ARB_TIMEOUT_EN adds a watchdog on the core: a job that
// never finishes returns resp_err=1 and the arbiter re-flushes the core.

module speck_core_arbiter
  import speck_core_arbiter_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int DATA_W         = ARB_DATA_W,
  parameter int FLUSH_CYCLES   = ARB_FLUSH_CYCLES,
  parameter int TIMEOUT_CYCLES = ARB_TIMEOUT_CYCLES
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_REQ-1:0]          req_valid,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic [NUM_REQ*DATA_W-1:0]   req_plaintext,
  input  logic [NUM_REQ*DATA_W-1:0]   req_key,
  output logic                        resp_valid,
  input  logic                        resp_ready,
  output logic [$clog2(NUM_REQ)-1:0]  resp_id,
  output logic [DATA_W-1:0]           resp_ciphertext,
  output logic                        resp_err,
  output logic                        core_start,
  output logic [DATA_W-1:0]           core_plaintext,
  output logic [DATA_W-1:0]           core_key,
  input  logic                        core_finished,
  input  logic [DATA_W-1:0]           core_ciphertext,
  output logic                        busy
);

  localparam int ID_W    = $clog2(NUM_REQ);
  localparam int FLUSH_W = $clog2(FLUSH_CYCLES + 1);
  localparam logic [FLUSH_W-1:0] FLUSH_LAST = FLUSH_W'(FLUSH_CYCLES - 1);

  // Both counters need at least one meaningful step; smaller values are unsupported
  if (FLUSH_CYCLES < 1 || TIMEOUT_CYCLES < 2) begin : g_unsupported_cycle_params
  end

  logic [2:0]         state;
  logic [FLUSH_W-1:0] flush_cnt;
  logic [ID_W-1:0]    rr_ptr;
  logic [ID_W-1:0]    gnt_id;

  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    grant_idx;
  logic               any_valid;

  rr_grant #(
    .N (NUM_REQ)
  ) u_rr_grant (
    .req       (req_valid),
    .ptr       (rr_ptr),
    .grant     (grant),
    .idx       (grant_idx),
    .any_valid (any_valid)
  );

  // Accept is only offered in IDLE, so at most one requester sees ready
  assign req_ready  = (state == ARB_IDLE) ? grant : '0;
  assign core_start = (state == ARB_LAUNCH);
  assign busy       = (state != ARB_IDLE);

`ifdef SPECK_ARB_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  logic [WD_W-1:0] wd_cnt;
  logic            wd_expired;

  assign wd_expired = (wd_cnt == WD_LAST);
`else
  assign resp_err = 1'b0;
`endif

  // Main arbiter FSM: flush, grant, launch, wait for the core, return result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= ARB_FLUSH;
      flush_cnt       <= '0;
      rr_ptr          <= '0;
      gnt_id          <= '0;
      core_plaintext  <= '0;
      core_key        <= '0;
      resp_valid      <= 1'b0;
      resp_id         <= '0;
      resp_ciphertext <= '0;
`ifdef SPECK_ARB_TIMEOUT_EN
      resp_err        <= 1'b0;
      wd_cnt          <= '0;
`endif
    end else begin
      case (state)
        ARB_FLUSH: begin
          if (flush_cnt == FLUSH_LAST) begin
            flush_cnt <= '0;
            state     <= ARB_IDLE;
          end else begin
            flush_cnt <= flush_cnt + 1'b1;
          end
        end

        ARB_IDLE: begin
          if (any_valid) begin
            gnt_id         <= grant_idx;
            core_plaintext <= req_plaintext[grant_idx*DATA_W +: DATA_W];
            core_key       <= req_key[grant_idx*DATA_W +: DATA_W];
            state          <= ARB_LAUNCH;
`ifdef SPECK_ARB_TIMEOUT_EN
            wd_cnt         <= '0;
`endif
          end
        end

        ARB_LAUNCH: begin
          state <= ARB_BUSY;
`ifdef SPECK_ARB_TIMEOUT_EN
          wd_cnt <= wd_cnt + 1'b1;
`endif
        end

        ARB_BUSY: begin
          if (core_finished) begin
            resp_ciphertext <= core_ciphertext;
            resp_id         <= gnt_id;
            resp_valid      <= 1'b1;
            state           <= ARB_RESP;
`ifdef SPECK_ARB_TIMEOUT_EN
            resp_err        <= 1'b0;
`endif
          end
`ifdef SPECK_ARB_TIMEOUT_EN
          else if (wd_expired) begin
            resp_ciphertext <= '0;
            resp_id         <= gnt_id;
            resp_valid      <= 1'b1;
            resp_err        <= 1'b1;
            state           <= ARB_RESP;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
`endif
        end

        ARB_RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            rr_ptr     <= ID_W'(rr_next(int'(gnt_id), NUM_REQ));
`ifdef SPECK_ARB_TIMEOUT_EN
            if (resp_err) begin
              resp_err  <= 1'b0;
              flush_cnt <= '0;
              state     <= ARB_FLUSH;
            end else begin
              state <= ARB_IDLE;
            end
`else
            state <= ARB_IDLE;
`endif
          end
        end

        default: begin
          flush_cnt <= '0;
          state     <= ARB_FLUSH;
        end
      endcase
    end
  end

endmodule
